// File: rtl/sdram_ch3_arbiter.sv
// sdram_ch3_arbiter: shares SDRAM channel 3 between ROM loader, CPU and audio fetcher,
// one ch_req per grant, with a bounded wait for ch_ready.
module sdram_ch3_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rom_mode,
  input  logic        rom_req,
  input  logic [24:1] rom_addr,
  input  logic [15:0] rom_din,
  input  logic [1:0]  rom_be,
  output logic        rom_ack,
  input  logic        cpu_req,
  input  logic [23:0] cpu_addr,
  input  logic [15:0] cpu_din,
  input  logic [1:0]  cpu_wr_sel,
  output logic [15:0] cpu_dout,
  output logic        cpu_ack,
  input  logic        aud_req,
  input  logic [23:0] aud_addr,
  output logic [15:0] aud_dout,
  output logic        aud_ack,
  output logic [23:0] ch_addr,
  output logic [15:0] ch_din,
  output logic [1:0]  ch_be,
  output logic        ch_rnw,
  output logic        ch_req,
  input  logic        ch_ready,
  input  logic [15:0] ch_dout,
  output logic        busy,
  output logic        timeout_err
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {G_NONE, G_ROM, G_CPU, G_AUD} grant_t;
  state_t        state, state_n;
  grant_t        grant, pick;
  logic [SW-1:0] streak, streak_n;
  logic [TW-1:0] cnt;
  logic          expire, fin;
  always_comb begin
    pick = rom_mode ? (rom_req ? G_ROM : G_NONE)
         : (cpu_req && !(aud_req && streak == SW'(STARVE_LIMIT))) ? G_CPU
         : aud_req ? G_AUD : G_NONE;
    expire = !ch_ready && cnt == TW'(TIMEOUT - 1);
    fin = ch_ready || expire;
    state_n = state;
    streak_n = streak;
    case (state)
      IDLE: begin
        state_n = pick == G_NONE ? IDLE : ISSUE;
        streak_n = (!aud_req || pick == G_AUD) ? '0
                 : (pick == G_CPU && streak != SW'(STARVE_LIMIT)) ? streak + SW'(1) : streak;
      end
      ISSUE:   state_n = WAIT;
      WAIT:    state_n = fin ? DONE : WAIT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= G_NONE;
      streak      <= '0;
      cnt         <= '0;
      ch_req      <= 1'b0;
      ch_rnw      <= 1'b1;
      ch_addr     <= '0;
      ch_din      <= '0;
      ch_be       <= '0;
      rom_ack     <= 1'b0;
      cpu_ack     <= 1'b0;
      aud_ack     <= 1'b0;
      cpu_dout    <= '0;
      aud_dout    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state   <= state_n;
      streak  <= streak_n;
      ch_req  <= state_n == ISSUE;
      busy    <= state_n != IDLE;
      rom_ack <= state_n == DONE && grant == G_ROM;
      cpu_ack <= state_n == DONE && grant == G_CPU;
      aud_ack <= state_n == DONE && grant == G_AUD;
      cnt     <= state == ISSUE ? '0 : state == WAIT ? cnt + TW'(1) : cnt;
      if (state == IDLE && pick != G_NONE) begin
        grant   <= pick;
        ch_addr <= pick == G_ROM ? rom_addr : pick == G_CPU ? cpu_addr : aud_addr;
        ch_din  <= pick == G_ROM ? rom_din : pick == G_CPU ? cpu_din : 16'h0000;
        ch_be   <= pick == G_ROM ? rom_be : pick == G_CPU ? cpu_wr_sel : 2'b11;
        ch_rnw  <= pick == G_ROM ? 1'b0 : pick == G_CPU ? ~|cpu_wr_sel : 1'b1;
      end
      // an abandoned read returns all-ones so the requester sees an obviously bad word
      if (state == WAIT && fin && ch_rnw) begin
        if (grant == G_CPU) cpu_dout <= ch_ready ? ch_dout : 16'hFFFF;
        if (grant == G_AUD) aud_dout <= ch_ready ? ch_dout : 16'hFFFF;
      end
      if (state == WAIT && expire) timeout_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sdram_ch3_arbiter.sv
// tb_sdram_ch3_arbiter: randomized self-checking bench against a transaction-level model
module tb_sdram_ch3_arbiter;
  localparam int L  = 4;
  localparam int TO = 255;
  logic        clk = 0, reset = 1;
  logic        rom_mode = 0, rom_req = 0, cpu_req = 0, aud_req = 0, ch_ready = 0;
  logic [24:1] rom_addr = '0;
  logic [15:0] rom_din = '0, cpu_din = '0, ch_dout = '0;
  logic [1:0]  rom_be = '0, cpu_wr_sel = '0;
  logic [23:0] cpu_addr = '0, aud_addr = '0;
  logic        rom_ack, cpu_ack, aud_ack, ch_rnw, ch_req, busy, timeout_err;
  logic [15:0] cpu_dout, aud_dout, ch_din;
  logic [23:0] ch_addr;
  logic [1:0]  ch_be;
  sdram_ch3_arbiter #(.STARVE_LIMIT(L), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .rom_mode(rom_mode), .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_din(rom_din), .rom_be(rom_be), .rom_ack(rom_ack), .cpu_req(cpu_req),
    .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_wr_sel(cpu_wr_sel), .cpu_dout(cpu_dout),
    .cpu_ack(cpu_ack), .aud_req(aud_req), .aud_addr(aud_addr), .aud_dout(aud_dout),
    .aud_ack(aud_ack), .ch_addr(ch_addr), .ch_din(ch_din), .ch_be(ch_be), .ch_rnw(ch_rnw),
    .ch_req(ch_req), .ch_ready(ch_ready), .ch_dout(ch_dout), .busy(busy),
    .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  int          checks = 0, errors = 0;
  int          streak = 0;
  logic [15:0] m_cpu = 0, m_aud = 0;
  logic        m_terr = 0;
  bit          after_ack = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  // 0 none, 1 rom, 2 cpu, 3 audio
  function automatic int exp_grant();
    if (rom_mode) return rom_req ? 1 : 0;
    if (cpu_req && !(aud_req && streak == L)) return 2;
    return aud_req ? 3 : 0;
  endfunction
  function automatic void model_grant(input int g);
    if (!aud_req || g == 3) streak = 0;
    else if (g == 2 && streak < L) streak++;
  endfunction
  task automatic raise_cpu();
    cpu_req = 1; cpu_addr = {1'b0, 23'($urandom)}; cpu_din = 16'($urandom);
    cpu_wr_sel = $urandom_range(0, 1) ? 2'b00 : 2'($urandom);
  endtask
  task automatic raise_aud();
    aud_req = 1; aud_addr = {1'b1, 23'($urandom)};
  endtask
  task automatic raise_rom();
    rom_req = 1; rom_addr = 24'($urandom); rom_din = 16'($urandom); rom_be = 2'($urandom);
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_ch_req"}, ch_req, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_acks"}, {rom_ack, cpu_ack, aud_ack}, 0);
    check({tag, "_terr"}, timeout_err, 0);
    check({tag, "_rnw"}, ch_rnw, 1);
    check({tag, "_addr"}, ch_addr, 0);
    check({tag, "_din"}, ch_din, 0);
    check({tag, "_be"}, ch_be, 0);
    check({tag, "_douts"}, {cpu_dout, aud_dout}, 0);
  endtask
  task automatic serve(input int g, input int d, input logic [15:0] data);
    logic [23:0] ea;
    logic [15:0] ed;
    logic [1:0]  eb;
    logic        er;
    bit          extra;
    ea = g == 1 ? 24'(rom_addr) : g == 2 ? cpu_addr : aud_addr;
    ed = g == 1 ? rom_din : g == 2 ? cpu_din : 16'h0000;
    eb = g == 1 ? rom_be : g == 2 ? cpu_wr_sel : 2'b11;
    er = g == 1 ? 1'b0 : g == 2 ? (cpu_wr_sel == 2'b00) : 1'b1;
    @(negedge clk);
    check("ch_req", ch_req, 1);
    check("ch_addr", ch_addr, ea);
    check("ch_din", ch_din, ed);
    check("ch_be", ch_be, eb);
    check("ch_rnw", ch_rnw, er);
    extra = 0;
    repeat (d) begin
      @(negedge clk);
      extra |= ch_req | rom_ack | cpu_ack | aud_ack | !busy;
    end
    ch_ready = 1; ch_dout = data;
    @(negedge clk);
    ch_ready = 0; ch_dout = 16'($urandom);
    if (er && g == 2) m_cpu = data;
    if (er && g == 3) m_aud = data;
    check("wait_quiet", extra, 0);
    check("rom_ack", rom_ack, g == 1);
    check("cpu_ack", cpu_ack, g == 2);
    check("aud_ack", aud_ack, g == 3);
    check("cpu_dout", cpu_dout, m_cpu);
    check("aud_dout", aud_dout, m_aud);
    check("terr", timeout_err, m_terr);
    if (g == 1) rom_req = 0;
    if (g == 2) cpu_req = 0;
    if (g == 3) aud_req = 0;
    after_ack = 1;
  endtask
  task automatic step(input int d, input logic [15:0] data);
    int g;
    bit extra;
    if (after_ack) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_quiet", {ch_req, rom_ack, cpu_ack, aud_ack}, 0);
      after_ack = 0;
    end
    g = exp_grant();
    model_grant(g);
    if (g != 0) serve(g, d, data);
    else begin
      extra = 0;
      repeat (4) begin
        @(negedge clk);
        extra |= ch_req | busy | rom_ack | cpu_ack | aud_ack;
      end
      check("no_grant", extra, 0);
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    int  t, ack_t, nack;
    bit  extra;
    repeat (3) @(negedge clk);
    check_reset("rst");
    reset = 0;
    cpu_req = 1; cpu_addr = 24'h000100; cpu_wr_sel = 2'b00; cpu_din = 16'h1234;
    step(5, 16'hBEEF);
    check("cpu_read_beef", cpu_dout, 16'hBEEF);
    cpu_req = 1; cpu_addr = 24'h000200; cpu_wr_sel = 2'b01; cpu_din = 16'h00A5;
    step(2, 16'h5A5A);
    check("cpu_write_hold", cpu_dout, 16'hBEEF);
    raise_cpu(); raise_aud();
    for (int i = 0; i < 15; i++) begin
      step($urandom_range(1, 6), 16'($urandom));
      if (!cpu_req) raise_cpu();
      if (!aud_req) raise_aud();
    end
    aud_req = 0; rom_mode = 1;
    for (int i = 0; i < 8; i++) begin
      rom_req = 1; rom_addr = 24'h001000 + 24'(i); rom_din = 16'($urandom); rom_be = 2'($urandom);
      step($urandom_range(1, 4), 16'($urandom));
    end
    rom_mode = 0;
    step(3, 16'($urandom));
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 3) == 0) rom_mode = ~rom_mode;
      if (!cpu_req && $urandom_range(0, 1)) raise_cpu();
      if (!aud_req && $urandom_range(0, 1)) raise_aud();
      if (!rom_req && $urandom_range(0, 1)) raise_rom();
      step($urandom_range(1, 6), 16'($urandom));
    end
    rom_mode = 0; rom_req = 0; cpu_req = 0; aud_req = 0;
    repeat (2) @(negedge clk);
    after_ack = 0;
    model_grant(0);
    raise_aud();
    model_grant(exp_grant());
    @(negedge clk);
    check("to_ch_req", ch_req, 1);
    ack_t = -1; nack = 0; extra = 0;
    for (t = 1; t <= 300; t++) begin
      @(negedge clk);
      ch_ready = 0;
      if (aud_ack) begin nack++; if (ack_t < 0) ack_t = t; aud_req = 0; end
      extra |= ch_req | cpu_ack | rom_ack;
      if (t == 280) ch_ready = 1;
    end
    ch_ready = 0;
    m_aud = 16'hFFFF; m_terr = 1;
    check("to_ack_cycle", ack_t, 256);
    check("to_ack_count", nack, 1);
    check("to_quiet", extra, 0);
    check("to_aud_dout", aud_dout, 16'hFFFF);
    check("to_terr", timeout_err, 1);
    check("to_idle", busy, 0);
    cpu_req = 1; cpu_addr = 24'h0ABCDE; cpu_wr_sel = 2'b00;
    model_grant(exp_grant());
    @(negedge clk);
    check("mid_ch_req", ch_req, 1);
    repeat (2) @(negedge clk);
    reset = 1; cpu_req = 0;
    #1;
    check_reset("mid");
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      extra |= cpu_ack | busy | ch_req;
    end
    check("mid_no_ack", extra, 0);
    reset = 0;
    streak = 0; m_cpu = 0; m_aud = 0; m_terr = 0; after_ack = 0;
    raise_cpu(); cpu_wr_sel = 2'b00;
    step(3, 16'hC0DE);
    raise_aud();
    step(1, 16'h7E57);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
